// File: rtl/silver_flit_sel.sv
// silver_flit_sel: registered silver-flit selector; marks one eligible (valid, non-golden) flit per cycle.
// Build option: define SILVER_ROUND_ROBIN_EN to use a round-robin pointer instead of the LFSR start index.
module silver_flit_sel #(
  parameter int         NPORTS     = 4,
  parameter int         FLIT_W     = 11,
  parameter int         GOLD_BIT   = 10,
  parameter int         SILVER_BIT = 9,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stage_en,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*FLIT_W-1:0] in_flit,
  output logic [NPORTS-1:0]        out_valid,
  output logic [NPORTS*FLIT_W-1:0] out_flit,
  output logic [NPORTS-1:0]        out_sel,
  output logic [CNT_W-1:0]         silver_cnt
);

  localparam int SEL_W = $clog2(NPORTS);

  logic [NPORTS-1:0]        out_valid_q, out_valid_d;
  logic [NPORTS*FLIT_W-1:0] out_flit_q,  out_flit_d;
  logic [NPORTS-1:0]        out_sel_q,   out_sel_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
`ifdef SILVER_ROUND_ROBIN_EN
  logic [SEL_W-1:0]         ptr_q,       ptr_d;
`else
  logic [7:0]               lfsr_q,      lfsr_d;
`endif

  logic [NPORTS-1:0] elig_s;
  logic [SEL_W-1:0]  start_s;
  logic [SEL_W-1:0]  win_s;
  logic              grant_s;

`ifndef SILVER_ROUND_ROBIN_EN
  // 8-bit Galois LFSR, right shift, taps 8'hB8
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction
`endif

  // Eligibility and first-eligible scan from the start index, wrapping modulo NPORTS
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx     = '0;
    elig_s  = '0;
    grant_s = 1'b0;
    win_s   = '0;
`ifdef SILVER_ROUND_ROBIN_EN
    start_s = ptr_q;
`else
    start_s = lfsr_q[SEL_W-1:0];
`endif
    for (int p = 0; p < NPORTS; p++) begin
      elig_s[p] = in_valid[p] & ~in_flit[p*FLIT_W + GOLD_BIT];
    end
    for (int i = 0; i < NPORTS; i++) begin
      idx = start_s + SEL_W'(i);
      if (!grant_s && elig_s[idx]) begin
        grant_s = 1'b1;
        win_s   = idx;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Next-state: marking, one-hot select, saturating counter and start-index state
  always_comb begin
    logic [FLIT_W-1:0] flit_v;
    flit_v      = '0;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    out_sel_d   = out_sel_q;
    cnt_d       = cnt_q;
`ifdef SILVER_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`else
    lfsr_d      = lfsr_q;
`endif
    if (stage_en) begin
      out_valid_d = in_valid;
      // Stale silver marks are dropped on every port, including invalid ones
      for (int p = 0; p < NPORTS; p++) begin
        flit_v             = in_flit[p*FLIT_W +: FLIT_W];
        flit_v[SILVER_BIT] = grant_s && (win_s == SEL_W'(p));
        out_flit_d[p*FLIT_W +: FLIT_W] = flit_v;
      end
      if (grant_s) begin
        out_sel_d = NPORTS'(1'b1) << win_s;
      end else begin
        out_sel_d = '0;
      end
      if (grant_s && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
`ifdef SILVER_ROUND_ROBIN_EN
      if (grant_s) begin
        ptr_d = win_s + SEL_W'(1'b1);
      end else begin
        ptr_d = ptr_q;
      end
`else
      lfsr_d = lfsr_next(lfsr_q);
`endif
    end else begin
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
    end
  end

  // State registers with asynchronous reset; reset drops any in-flight flit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_flit_q  <= '0;
      out_sel_q   <= '0;
      cnt_q       <= '0;
`ifdef SILVER_ROUND_ROBIN_EN
      ptr_q       <= '0;
`else
      lfsr_q      <= LFSR_SEED;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_sel_q   <= out_sel_d;
      cnt_q       <= cnt_d;
`ifdef SILVER_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`else
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_flit   = out_flit_q;
  assign out_sel    = out_sel_q;
  assign silver_cnt = cnt_q;

endmodule

// File: doc/silver_flit_sel.md
# silver_flit_sel

Registered, parametrised silver-flit selector for the MinBD router pipeline. Each cycle it takes NPORTS incoming flits and clears any stale silver marking. It then picks one eligible (valid, non-golden) flit with a pseudo-random rotating priority and sets its silver bit. The stage sits between the golden-flit stage and the permutation network; its outputs are registered, replacing the old combinational, simulation-only random pick.

## Interface
- NPORTS, 4: flit ports; power of two, 2..16
- FLIT_W, 11: flit width
- GOLD_BIT, 10: golden-flag bit index
- SILVER_BIT, 9: silver-flag bit index
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero
- CNT_W, 16: width of silver_cnt

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stage_en  in  1  pipeline advance; when low, all state holds
- in_valid  in  NPORTS  per-port flit valid
- in_flit  in  NPORTS*FLIT_W  flits; port p occupies [p*FLIT_W +: FLIT_W]
- out_valid  out  NPORTS  registered copy of in_valid
- out_flit  out  NPORTS*FLIT_W  registered flits with silver marking applied
- out_sel  out  NPORTS  one-hot port given silver this cycle; all-zero if none
- silver_cnt  out  CNT_W  saturating count of silver grants

## Operation
- Eligibility: elig[p] = in_valid[p] & ~in_flit[p][GOLD_BIT].
- Start index S:
  - Default build: the low log2(NPORTS) bits of the current LFSR value.
  - SILVER_ROUND_ROBIN_EN build: the round-robin pointer.
- Winner: the first eligible port at or after S, scanning in order S, S+1, …, wrapping modulo NPORTS.
- Flit marking:
  - SILVER_BIT is cleared on every output flit.
  - SILVER_BIT is then set only on the winner.
  - All other bits pass unchanged.
  - Invalid ports' flits also pass through, with SILVER_BIT cleared.
- Grant limit: at most one silver flit per cycle. If no port is eligible (all invalid or all golden), out_sel = 0 and no flit is marked.
- LFSR: 8-bit Galois, right shift. Next value = (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 0). It advances on every stage_en cycle, regardless of whether a grant occurs.
- silver_cnt: increments on each stage_en cycle with a grant; it saturates at all-ones.

## Timing
- Latency: 1 cycle. Inputs sampled at edge k (stage_en = 1) appear on outputs after edge k.
- stage_en = 0: outputs, LFSR, pointer and counter all hold their values. Inputs are ignored.
- Reset values, held while rst is high:
  - out_valid = 0
  - out_flit = 0
  - out_sel = 0
  - silver_cnt = 0
  - LFSR = LFSR_SEED
  - round-robin pointer = 0
- Reset mid-operation: the in-flight flit is dropped. No partial marking is visible.
- No combinational path from inputs to outputs.

## Configuration
- SILVER_ROUND_ROBIN_EN defined:
  - The LFSR is removed.
  - S comes from a log2(NPORTS)-bit pointer.
  - On a grant, the pointer becomes (winner+1) mod NPORTS.
  - With no grant, the pointer holds.
  - Gives deterministic fairness for verification and debug.
- Undefined: LFSR-based start index as described under Operation.

## Test plan
- Reset: assert rst asynchronously mid-cycle, with input flits present -> all outputs 0 immediately; LFSR = 8'hA5; after release, first edge uses S = 1.
- LFSR pick, default build, 4 ports all valid and non-golden:
  - First cycle: S = 1, out_sel = 4'b0010, port 1 SILVER_BIT = 1.
  - Next cycle: LFSR = 8'hEA, S = 2, out_sel = 4'b0100.
- Skip golden and wrap: S = 3, port 3 golden, port 0 invalid, ports 1-2 eligible -> out_sel = 4'b0010; port 3 flit unchanged except SILVER_BIT = 0.
- No eligible port: all ports golden, or in_valid = 0 -> out_sel = 0, no SILVER_BIT set, silver_cnt unchanged, LFSR still advances.
- Stale silver bit: inputs arrive with SILVER_BIT = 1 on all ports, only port 2 eligible -> only port 2 output has SILVER_BIT = 1.
- Stall and round-robin (SILVER_ROUND_ROBIN_EN, all eligible):
  - Grants go 0, 1, 2, 3, 0.
  - stage_en low for 3 cycles -> outputs and pointer frozen.
  - silver_cnt with CNT_W = 2 saturates at 3.
